booth_scheduler: RTL and testbench

Two-port round-robin scheduler and sequencer for the shared radix-2 Booth multiplier datapath (A/Q/M registers, adder/subtractor, arithmetic shifter). Two requesters compete for the datapath through a req/ack handshake. The block arbitrates between them and steers the operand mux. It then drives the load/add/subtract/shift strobes for N Booth iterations and signals completion to the winning requester. It replaces the fixed 3-iteration `start`-driven sequencer and adds a reset and a width parameter.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_scheduler_rr_arbiter2.sv | 54 +++++
 rtl/booth_scheduler.sv | 161 ++++++++++++++++
 tb/tb_booth_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth multiplier scheduler.
//   - state_e   : scheduler FSM state encoding
//   - Q_ADD/SUB : {Q[0],Q[-1]} patterns that request an add / subtract
//   - N_DEFAULT : default operand width (= Booth iteration count)
package booth_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic [1:0] Q_ADD = 2'b01;
  localparam logic [1:0] Q_SUB = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/booth_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_i[1:0]  - request vector
//   update_i    - load the pointer with gnt_id_i (end of a served job)
//   gnt_id_i    - id of the requester just served
//   winner_o    - id of the requester that wins this cycle
// The pointer remembers the last served requester; on a tie the other one
// wins. It resets to 1 so requester 0 takes the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       gnt_id_i,
  output logic       winner_o
);

  logic ptr_q;
  logic ptr_d;

  function automatic logic grant2(input logic [1:0] req, input logic ptr);
    logic w;
    case (req)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      2'b11:   w = ~ptr;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Pointer next-state: follow the served id when a job completes.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      ptr_d = gnt_id_i;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign winner_o = grant2(req_i, ptr_q);

endmodule

// File: rtl/booth_scheduler.sv
// booth_scheduler: round-robin scheduler and sequencer for a shared radix-2
// Booth multiplier datapath (A/Q/M registers, adder/subtractor, shifter).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req0_i, req1_i        - requests, held high until the matching ack
//   ack0_o, ack1_o        - pulse in LOAD for the selected requester
//   done0_o, done1_o      - pulse in DONE for the selected requester
//   busy_o                - high in every state except IDLE
//   sel_o                 - operand mux select, fixed from LOAD to DONE
//   q_i                   - {Q[0], Q[-1]} from the datapath
//   cargaQ_o, cargaM_o    - load multiplier / multiplicand (clears A, Q[-1])
//   cargaA_o, resta_o     - load A with A+M (resta=0) or A-M (resta=1)
//   desp_o                - arithmetic right shift of A:Q:Q[-1]
//   fin_o                 - high in DONE
module booth_scheduler
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic       busy_o,
  output logic       sel_o,
  input  logic [1:0] q_i,
  output logic       cargaQ_o,
  output logic       cargaM_o,
  output logic       cargaA_o,
  output logic       resta_o,
  output logic       desp_o,
  output logic       fin_o
);

  localparam int CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;

  logic winner_s;
  logic arb_update_s;
  logic ack0_s, ack1_s, done0_s, done1_s;
  logic carga_qm_s, carga_a_s, resta_s, desp_s, fin_s;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_i, req0_i}),
    .update_i (arb_update_s),
    .gnt_id_i (sel_q),
    .winner_o (winner_s)
  );

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    arb_update_s = 1'b0;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    done0_s      = 1'b0;
    done1_s      = 1'b0;
    carga_qm_s   = 1'b0;
    carga_a_s    = 1'b0;
    resta_s      = 1'b0;
    desp_s       = 1'b0;
    fin_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // sel only ever changes here, on the way into LOAD
        if (req0_i || req1_i) begin
          sel_d   = winner_s;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        carga_qm_s = 1'b1;
        if (sel_q) begin
          ack1_s = 1'b1;
        end else begin
          ack0_s = 1'b1;
        end
        cnt_d   = CW'(N);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if ((q_i == Q_ADD) || (q_i == Q_SUB)) begin
          carga_a_s = 1'b1;
          resta_s   = (q_i == Q_SUB);
          state_d   = S_SHIFT;
        end else begin
          // shift-only iteration: finishes the iteration in this cycle
          desp_s = 1'b1;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_SHIFT: begin
        desp_s = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_DONE: begin
        fin_s        = 1'b1;
        arb_update_s = 1'b1;
        if (sel_q) begin
          done1_s = 1'b1;
        end else begin
          done0_s = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, iteration counter and operand select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign ack0_o   = ack0_s;
  assign ack1_o   = ack1_s;
  assign done0_o  = done0_s;
  assign done1_o  = done1_s;
  assign busy_o   = (state_q != S_IDLE);
  assign sel_o    = sel_q;
  assign cargaQ_o = carga_qm_s;
  assign cargaM_o = carga_qm_s;
  assign cargaA_o = carga_a_s;
  assign resta_o  = resta_s;
  assign desp_o   = desp_s;
  assign fin_o    = fin_s;

endmodule

// File: tb/tb_booth_scheduler.sv
// Directed bench for booth_scheduler with an N=4 behavioral Booth datapath.
module tb_booth_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic ack0, ack1, done0, done1, busy, sel;
  logic cargaQ, cargaM, cargaA, resta, desp, fin;
  logic [1:0] q_dp;

  int vectors = 0;
  int errors  = 0;

  // Operands presented by each requester
  logic [3:0] m0 = 4'd0, x0 = 4'd0, m1 = 4'd0, x1 = 4'd0;

  // Datapath model; A carries a guard bit so M = -8 subtracts correctly
  logic [4:0] a_m = 5'd0;
  logic [3:0] q_m = 4'd0, mm_m = 4'd0;
  logic       q1_m = 1'b0;

  always #5 clk = ~clk;

  booth_scheduler #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .ack0_o(ack0), .ack1_o(ack1), .done0_o(done0), .done1_o(done1),
    .busy_o(busy), .sel_o(sel), .q_i(q_dp),
    .cargaQ_o(cargaQ), .cargaM_o(cargaM), .cargaA_o(cargaA),
    .resta_o(resta), .desp_o(desp), .fin_o(fin)
  );

  always @(posedge clk) begin
    if (cargaQ && cargaM) begin
      a_m  <= 5'd0;
      q1_m <= 1'b0;
      q_m  <= sel ? x1 : x0;
      mm_m <= sel ? m1 : m0;
    end else if (cargaA) begin
      a_m <= resta ? a_m - {mm_m[3], mm_m} : a_m + {mm_m[3], mm_m};
    end else if (desp) begin
      {a_m, q_m, q1_m} <= {a_m[4], a_m, q_m};
    end
  end
  assign q_dp = {q_m[0], q1_m};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int id, output int n, output logic s);
    id = -1; n = 0; s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (ack0 || ack1) begin
        id = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        s  = sel;
        break;
      end
    end
  endtask

  task automatic wait_done(output int id, output int n);
    id = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (done0 || done1) begin
        id = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    int dn, id, n;
    logic s;
    rst_n = 1'b0;
    step(); step();
    outs = {ack0, ack1, done0, done1, busy, sel, cargaQ, cargaM, cargaA, resta, desp, fin};
    vectors++;
    if (outs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h want 000", outs); end
    rst_n = 1'b1;
    step();
    // start a job, then pull reset in its first EVAL
    m0 = 4'd3; x0 = 4'd5; req0 = 1'b1;
    step(); step();
    vectors++;
    if (cargaA !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_eval: cargaA=%b busy=%b want 1 1", cargaA, busy);
    end
    rst_n = 1'b0;
    #1;
    outs = {ack0, ack1, done0, done1, busy, sel, cargaQ, cargaM, cargaA, resta, desp, fin};
    vectors++;
    if (outs !== 12'h000) begin errors++; $display("FAIL midjob_reset_outputs: got %h want 000", outs); end
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 || done1) dn++;
    end
    rst_n = 1'b1;
    vectors++;
    if (dn !== 0) begin errors++; $display("FAIL reset_no_done: got %0d want 0", dn); end
    wait_ack(id, n, s);
    vectors++;
    if (id !== 0 || n !== 1) begin
      errors++; $display("FAIL post_reset_ack: id=%0d lat=%0d want id=0 lat=1", id, n);
    end
    req0 = 1'b0;
    wait_done(id, n);
    vectors++;
    if (id !== 0) begin errors++; $display("FAIL post_reset_done: id=%0d want 0", id); end
    step();
  endtask

  task automatic run_job(input string tag, input int who, input logic [3:0] m, input logic [3:0] x,
                         input int exp_done, input logic [7:0] exp_prod, input int exp_adds,
                         input logic [3:0] exp_pat);
    int ack_cyc = -1, done_cyc = -1, adds = 0, bad_resta = 0, wrong = 0;
    int busy_gap = 0, fin_bad = 0, sel_bad = 0;
    logic [3:0] pat = 4'd0;
    logic [7:0] prod = 8'd0;
    if (who == 0) begin m0 = m; x0 = x; req0 = 1'b1; end
    else begin m1 = m; x1 = x; req1 = 1'b1; end
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      step();
      if (ack0 || ack1) begin
        if (ack_cyc < 0) ack_cyc = c;
        if ((who == 0 && (!ack0 || ack1)) || (who == 1 && (!ack1 || ack0))) wrong++;
        req0 = 1'b0; req1 = 1'b0;
      end
      if (ack_cyc >= 0 && busy !== 1'b1) busy_gap++;
      if (ack_cyc >= 0 && sel !== who[0]) sel_bad++;
      if (cargaA) begin adds++; pat = {pat[2:0], resta}; end
      else if (resta) bad_resta++;
      if (fin !== (done0 | done1)) fin_bad++;
      if (done0 || done1) begin
        done_cyc = c;
        prod = {a_m[3:0], q_m};
        if ((who == 0 && !done0) || (who == 1 && !done1)) wrong++;
      end
    end
    vectors++;
    if (ack_cyc !== 1) begin errors++; $display("FAIL %s ack_cycle: got %0d want 1", tag, ack_cyc); end
    vectors++;
    if (done_cyc !== exp_done) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_done); end
    vectors++;
    if (prod !== exp_prod) begin errors++; $display("FAIL %s product: got %h want %h", tag, prod, exp_prod); end
    vectors++;
    if (adds !== exp_adds) begin errors++; $display("FAIL %s cargaA_count: got %0d want %0d", tag, adds, exp_adds); end
    vectors++;
    if (pat !== exp_pat) begin errors++; $display("FAIL %s resta_pattern: got %b want %b", tag, pat, exp_pat); end
    vectors++;
    if (bad_resta !== 0 || wrong !== 0 || fin_bad !== 0) begin
      errors++; $display("FAIL %s strobes: stray_resta=%0d wrong_id=%0d fin_bad=%0d want 0 0 0", tag, bad_resta, wrong, fin_bad);
    end
    vectors++;
    if (busy_gap !== 0 || sel_bad !== 0) begin
      errors++; $display("FAIL %s busy_sel: busy_gaps=%0d sel_bad=%0d want 0 0", tag, busy_gap, sel_bad);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_after: busy=%b want 0", tag, busy); end
  endtask

  task automatic test_tie();
    int id, n;
    logic s;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    m0 = 4'd2; x0 = 4'd0; m1 = 4'd5; x1 = 4'd0;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(id, n, s);
    vectors++;
    if (id !== 0 || s !== 1'b0 || n !== 1) begin
      errors++; $display("FAIL tie_first: id=%0d sel=%b lat=%0d want 0 0 1", id, s, n);
    end
    req0 = 1'b0;
    wait_done(id, n);
    wait_ack(id, n, s);
    vectors++;
    if (id !== 1 || s !== 1'b1 || n !== 2) begin
      errors++; $display("FAIL tie_second: id=%0d sel=%b gap=%0d want 1 1 2", id, s, n);
    end
    req1 = 1'b0;
    wait_done(id, n);
    vectors++;
    if (id !== 1) begin errors++; $display("FAIL tie_done1: id=%0d want 1", id); end
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(id, n, s);
    vectors++;
    if (id !== 0 || s !== 1'b0 || n !== 2) begin
      errors++; $display("FAIL tie_rereq: id=%0d sel=%b gap=%0d want 0 0 2", id, s, n);
    end
    req0 = 1'b0;
    wait_done(id, n);
    wait_ack(id, n, s);
    vectors++;
    if (id !== 1 || s !== 1'b1 || n !== 2) begin
      errors++; $display("FAIL tie_rereq_second: id=%0d sel=%b gap=%0d want 1 1 2", id, s, n);
    end
    req1 = 1'b0;
    wait_done(id, n);
    step();
  endtask

  task automatic test_drop();
    int ack1_n = 0, done1_n = 0, done0_cyc = -1, busy_after = 0;
    m0 = 4'd3; x0 = 4'd5; req0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ack0) req0 = 1'b0;
      if (c == 3) req1 = 1'b1;
      if (c == 6) req1 = 1'b0;
      if (ack1) ack1_n++;
      if (done1) done1_n++;
      if (done0) done0_cyc = c;
      if (done0_cyc >= 0 && c > done0_cyc && busy) busy_after++;
    end
    vectors++;
    if (ack1_n !== 0 || done1_n !== 0) begin
      errors++; $display("FAIL drop_req1: ack1=%0d done1=%0d want 0 0", ack1_n, done1_n);
    end
    vectors++;
    if (done0_cyc !== 10) begin errors++; $display("FAIL drop_done0: got %0d want 10", done0_cyc); end
    vectors++;
    if (busy_after !== 0) begin errors++; $display("FAIL drop_busy_after: got %0d want 0", busy_after); end
  endtask

  initial begin
    test_reset();
    run_job("m3x5", 0, 4'd3, 4'd5, 10, 8'h0F, 4, 4'b1010);
    run_job("m7x0", 1, 4'd7, 4'd0, 6, 8'h00, 0, 4'b0000);
    run_job("mneg8", 0, 4'b1000, 4'b1000, 7, 8'h40, 1, 4'b0001);
    test_tie();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
